// File: rtl/rsa_axi_pkg.sv
// Shared types and constants for the AXI burst responder and its word RAM.
package rsa_axi_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WRESP = 2'd2,
    READ  = 2'd3
  } state_e;

endpackage

// File: rtl/rsa_word_ram.sv
// Single-port byte-enabled word RAM with a registered read port.
// Array contents are never reset; only the read register is.
module rsa_word_ram
  import rsa_axi_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [STRB_W-1:0] we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_zero,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // rd_zero loads zero instead of the array word; a disabled port holds its value.
  always_comb begin
    rdata_d = rdata_q;
    if (en) rdata_d = rd_zero ? '0 : mem[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/rsa_axi_burst_responder.sv
// AXI INCR burst responder backed by a word RAM: one burst at a time,
// alternating AW/AR grant, SLVERR on out-of-range beats or WLAST misplacement.
module rsa_axi_burst_responder
  import rsa_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [LEN_W-1:0]      S_AXI_AWLEN,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [DATA_W-1:0]     S_AXI_WDATA,
  input  logic [STRB_W-1:0]     S_AXI_WSTRB,
  input  logic                  S_AXI_WLAST,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [RESP_W-1:0]     S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [LEN_W-1:0]      S_AXI_ARLEN,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [DATA_W-1:0]     S_AXI_RDATA,
  output logic [RESP_W-1:0]     S_AXI_RRESP,
  output logic                  S_AXI_RLAST,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY
);

  localparam int unsigned WIDX_W = ADDR_WIDTH - 2;
  // One bit wider than any reachable index so bursts run past the end without wrapping.
  localparam int unsigned IDX_W  = ((WIDX_W > LEN_W) ? WIDX_W : LEN_W) + 1;
  localparam int unsigned RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  function automatic logic oor(input logic [IDX_W-1:0] idx);
    return 32'(idx) >= 32'(DEPTH_WORDS);
  endfunction

  state_e              state_q, state_d;
  logic                wr_pri_q, wr_pri_d;
  logic                awready_q, awready_d;
  logic                arready_q, arready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [RESP_W-1:0]   bresp_q, bresp_d;
  logic                rvalid_q, rvalid_d;
  logic [RESP_W-1:0]   rresp_q, rresp_d;
  logic                rlast_q, rlast_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                err_q, err_d;
  logic [1:0]          rst_sync_q, rst_sync_d;

  logic [IDX_W-1:0]    aw_idx_c, ar_idx_c, idx_nxt_c;
  logic [LEN_W-1:0]    beat_nxt_c;
  logic                acc_en_c, at_len_c, w_bad_c;
  logic                ram_en_c, ram_zero_c;
  logic [STRB_W-1:0]   ram_we_c;
  logic [IDX_W-1:0]    ram_idx_c;
  logic                unused_c;

  assign aw_idx_c   = IDX_W'(S_AXI_AWADDR[ADDR_WIDTH-1:2]);
  assign ar_idx_c   = IDX_W'(S_AXI_ARADDR[ADDR_WIDTH-1:2]);
  assign idx_nxt_c  = idx_q + IDX_W'(1);
  assign beat_nxt_c = beat_q + LEN_W'(1);
  assign acc_en_c   = rst_sync_q[1];
  assign unused_c   = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Reset release synchroniser: addresses are taken only once both stages are set.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  always_comb begin
    state_d    = state_q;
    wr_pri_d   = wr_pri_q;
    awready_d  = 1'b0;
    arready_d  = 1'b0;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    idx_d      = idx_q;
    beat_d     = beat_q;
    len_d      = len_q;
    err_d      = err_q;
    ram_en_c   = 1'b0;
    ram_we_c   = '0;
    ram_idx_c  = idx_q;
    ram_zero_c = 1'b0;
    at_len_c   = (beat_q == len_q);
    w_bad_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (awready_q && S_AXI_AWVALID) begin
          state_d  = WRITE;
          wready_d = 1'b1;
          wr_pri_d = 1'b0;
          idx_d    = aw_idx_c;
          beat_d   = '0;
          len_d    = S_AXI_AWLEN;
          err_d    = 1'b0;
        end else if (arready_q && S_AXI_ARVALID) begin
          // First beat is fetched in the handshake cycle so it is valid next cycle.
          state_d    = READ;
          wr_pri_d   = 1'b1;
          idx_d      = ar_idx_c;
          beat_d     = '0;
          len_d      = S_AXI_ARLEN;
          ram_en_c   = 1'b1;
          ram_idx_c  = ar_idx_c;
          ram_zero_c = oor(ar_idx_c);
          rvalid_d   = 1'b1;
          rresp_d    = oor(ar_idx_c) ? RESP_SLVERR : RESP_OKAY;
          rlast_d    = (S_AXI_ARLEN == '0);
        end else if (acc_en_c && !awready_q && !arready_q) begin
          if (S_AXI_AWVALID && (wr_pri_q || !S_AXI_ARVALID)) awready_d = 1'b1;
          else if (S_AXI_ARVALID)                             arready_d = 1'b1;
        end
      end

      WRITE: begin
        if (S_AXI_WVALID) begin
          ram_en_c = 1'b1;
          ram_we_c = oor(idx_q) ? '0 : S_AXI_WSTRB;
          w_bad_c  = oor(idx_q) || (S_AXI_WLAST != at_len_c);
          idx_d    = idx_nxt_c;
          beat_d   = beat_nxt_c;
          err_d    = err_q || w_bad_c;
          // Burst closes on WLAST or on beat AWLEN, whichever arrives first.
          if (S_AXI_WLAST || at_len_c) begin
            state_d  = WRESP;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = (err_q || w_bad_c) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end

      WRESP: begin
        if (S_AXI_BREADY) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
          bresp_d  = RESP_OKAY;
        end
      end

      READ: begin
        if (S_AXI_RREADY) begin
          if (rlast_q) begin
            state_d  = IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            rresp_d  = RESP_OKAY;
          end else begin
            idx_d      = idx_nxt_c;
            beat_d     = beat_nxt_c;
            ram_en_c   = 1'b1;
            ram_idx_c  = idx_nxt_c;
            ram_zero_c = oor(idx_nxt_c);
            rresp_d    = oor(idx_nxt_c) ? RESP_SLVERR : RESP_OKAY;
            rlast_d    = (beat_nxt_c == len_q);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      wr_pri_q   <= 1'b1;
      awready_q  <= 1'b0;
      arready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rlast_q    <= 1'b0;
      idx_q      <= '0;
      beat_q     <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      rst_sync_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      wr_pri_q   <= wr_pri_d;
      awready_q  <= awready_d;
      arready_q  <= arready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
      idx_q      <= idx_d;
      beat_q     <= beat_d;
      len_q      <= len_d;
      err_q      <= err_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  rsa_word_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (RAM_AW)
  ) u_ram (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .en     (ram_en_c),
    .we     (ram_we_c),
    .addr   (RAM_AW'(ram_idx_c)),
    .wdata  (S_AXI_WDATA),
    .rd_zero(ram_zero_c),
    .rdata  (S_AXI_RDATA)
  );

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;

endmodule

// File: tb/tb_rsa_axi_burst_responder.sv
// Scoreboard bench for rsa_axi_burst_responder: a reference memory model
// produces expected B responses and read beats, compared as the DUT emits them.
module tb_rsa_axi_burst_responder;

  localparam int AW    = 12;
  localparam int DEPTH = 1024;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic [AW-1:0] S_AXI_AWADDR;
  logic [7:0]    S_AXI_AWLEN;
  logic          S_AXI_AWVALID;
  logic          S_AXI_AWREADY;
  logic [31:0]   S_AXI_WDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic          S_AXI_WLAST;
  logic          S_AXI_WVALID;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY;
  logic [AW-1:0] S_AXI_ARADDR;
  logic [7:0]    S_AXI_ARLEN;
  logic          S_AXI_ARVALID;
  logic          S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RLAST;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY;

  always #5 ACLK = ~ACLK;

  rsa_axi_burst_responder #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  rbeat_t      rq[$];
  logic [1:0]  bq[$];
  logic [31:0] mem_m [DEPTH];
  int          n_chk = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push_read(input logic [AW-1:0] addr, input int len);
    int base;
    base = int'(addr[AW-1:2]);
    for (int i = 0; i <= len; i++) begin
      rbeat_t e;
      int     idx;
      idx = base + i;
      if (idx < DEPTH) begin
        e.data = mem_m[idx];
        e.resp = 2'b00;
      end else begin
        e.data = 32'h0;
        e.resp = 2'b10;
      end
      e.last = (i == len);
      rq.push_back(e);
    end
  endtask

  task automatic aw_phase(input logic [AW-1:0] addr, input int len);
    int n;
    S_AXI_AWADDR  = addr;
    S_AXI_AWLEN   = 8'(len);
    S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 200) begin tick(); n++; end
    if (!S_AXI_AWREADY) begin
      chk("aw_timeout", 32'd0, 32'd1);
      S_AXI_AWVALID = 1'b0;
      return;
    end
    tick();
    S_AXI_AWVALID = 1'b0;
  endtask

  task automatic w_phase(input logic [AW-1:0] addr, input int len, input logic [31:0] base,
                         input logic [3:0] strb, input int wlast_at);
    int   nb, n, idx;
    logic err;
    nb  = ((wlast_at < len) ? wlast_at : len) + 1;
    err = (wlast_at != len);
    for (int i = 0; i < nb; i++) begin
      S_AXI_WDATA  = base + 32'(i);
      S_AXI_WSTRB  = strb;
      S_AXI_WLAST  = (i == wlast_at);
      S_AXI_WVALID = 1'b1;
      n = 0;
      while (!S_AXI_WREADY && n < 200) begin tick(); n++; end
      if (!S_AXI_WREADY) begin
        chk("w_timeout", 32'd0, 32'd1);
        break;
      end
      idx = int'(addr[AW-1:2]) + i;
      if (idx < DEPTH) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) mem_m[idx][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
      end else begin
        err = 1'b1;
      end
      tick();
    end
    S_AXI_WVALID = 1'b0;
    S_AXI_WLAST  = 1'b0;
    bq.push_back(err ? 2'b10 : 2'b00);
  endtask

  task automatic b_phase(input int hold);
    int n;
    logic [1:0] e;
    repeat (hold) begin
      chk("bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
      tick();
    end
    S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_BVALID && n < 200) begin tick(); n++; end
    e = (bq.size() > 0) ? bq.pop_front() : 2'b11;
    if (!S_AXI_BVALID) chk("b_timeout", 32'd0, 32'd1);
    else               chk("bresp", 32'(S_AXI_BRESP), 32'(e));
    tick();
    S_AXI_BREADY = 1'b0;
    chk("bvalid_clr", 32'(S_AXI_BVALID), 32'd0);
  endtask

  task automatic ar_phase(input logic [AW-1:0] addr, input int len);
    int n;
    S_AXI_ARADDR  = addr;
    S_AXI_ARLEN   = 8'(len);
    S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 200) begin tick(); n++; end
    if (!S_AXI_ARREADY) begin
      chk("ar_timeout", 32'd0, 32'd1);
      S_AXI_ARVALID = 1'b0;
      return;
    end
    tick();
    S_AXI_ARVALID = 1'b0;
    chk("rvalid_lat", 32'(S_AXI_RVALID), 32'd1);
  endtask

  // mode 0: always ready, 1: ready 1,0,1,0..., 2: random. abort_at >= 0 resets mid-burst.
  task automatic r_phase(input int mode, input int abort_at);
    int beats, n;
    rbeat_t e;
    beats = 0;
    n = 0;
    while (rq.size() > 0 && n < 5000) begin
      case (mode)
        0:       S_AXI_RREADY = 1'b1;
        1:       S_AXI_RREADY = (n % 2 == 0);
        default: S_AXI_RREADY = 1'($urandom_range(0, 1));
      endcase
      if (abort_at >= 0 && beats == abort_at) begin
        chk("pre_rst_rvalid", 32'(S_AXI_RVALID), 32'd1);
        ARESETN = 1'b0;
        #1;
        chk("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        chk("rst_rlast", 32'(S_AXI_RLAST), 32'd0);
        chk("rst_rdata", S_AXI_RDATA, 32'd0);
        chk("rst_rresp", 32'(S_AXI_RRESP), 32'd0);
        rq.delete();
        S_AXI_RREADY = 1'b0;
        return;
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        e = rq.pop_front();
        chk("rdata", S_AXI_RDATA, e.data);
        chk("rresp", 32'(S_AXI_RRESP), 32'(e.resp));
        chk("rlast", 32'(S_AXI_RLAST), 32'(e.last));
        beats++;
      end else if (S_AXI_RVALID) begin
        chk("rdata_stall", S_AXI_RDATA, rq[0].data);
      end
      tick();
      n++;
    end
    S_AXI_RREADY = 1'b0;
    if (rq.size() > 0) begin
      chk("r_timeout", 32'(rq.size()), 32'd0);
      rq.delete();
    end else begin
      chk("rvalid_end", 32'(S_AXI_RVALID), 32'd0);
    end
  endtask

  task automatic wr_burst(input logic [AW-1:0] addr, input int len, input logic [31:0] base,
                          input logic [3:0] strb, input int wlast_at);
    aw_phase(addr, len);
    w_phase(addr, len, base, strb, wlast_at);
    b_phase(1);
  endtask

  task automatic rd_burst(input logic [AW-1:0] addr, input int len, input int mode);
    push_read(addr, len);
    ar_phase(addr, len);
    r_phase(mode, -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0;  S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    repeat (3) tick();

    chk("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    chk("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    chk("rst_wready",  32'(S_AXI_WREADY),  32'd0);
    chk("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
    chk("rst_bresp",   32'(S_AXI_BRESP),   32'd0);
    chk("rst_rvalid0", 32'(S_AXI_RVALID),  32'd0);
    chk("rst_rlast0",  32'(S_AXI_RLAST),   32'd0);
    chk("rst_rresp0",  32'(S_AXI_RRESP),   32'd0);
    chk("rst_rdata0",  S_AXI_RDATA,        32'd0);

    ARESETN = 1'b1;
    repeat (2) tick();

    // 256-beat write and read-back with random back-pressure
    wr_burst(12'h000, 255, 32'h1000_0000, 4'hF, 255);
    rd_burst(12'h000, 255, 2);

    // 8-beat write of 1..8 and read-back
    wr_burst(12'h000, 7, 32'd1, 4'hF, 7);
    rd_burst(12'h000, 7, 0);

    // byte-strobe merge
    wr_burst(12'h010, 0, 32'hAABB_CCDD, 4'hF, 0);
    wr_burst(12'h010, 0, 32'h1122_3344, 4'h5, 0);
    rd_burst(12'h010, 0, 0);

    // burst running off the end of memory
    wr_burst(12'hFF8, 3, 32'h0000_0100, 4'hF, 3);
    rd_burst(12'hFF8, 3, 1);

    // early and missing WLAST
    wr_burst(12'h200, 3, 32'h2000_0000, 4'hF, 1);
    rd_burst(12'h200, 1, 0);
    wr_burst(12'h300, 1, 32'h3000_0000, 4'hF, 9);
    rd_burst(12'h300, 1, 0);

    // reset in the middle of a read, then read the retained contents
    push_read(12'h000, 7);
    ar_phase(12'h000, 7);
    r_phase(0, 2);
    S_AXI_ARADDR  = 12'h000;
    S_AXI_ARLEN   = 8'd7;
    S_AXI_ARVALID = 1'b1;
    repeat (2) tick();
    #3 ARESETN = 1'b1;
    chk("rel_arready", 32'(S_AXI_ARREADY), 32'd0);
    tick();
    rd_burst(12'h000, 7, 0);

    // simultaneous AW/AR: write granted first, read second
    S_AXI_AWADDR  = 12'h100; S_AXI_AWLEN = 8'd0; S_AXI_AWVALID = 1'b1;
    S_AXI_ARADDR  = 12'h000; S_AXI_ARLEN = 8'd3; S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && !S_AXI_ARREADY && n < 200) begin tick(); n++; end
    chk("arb1_awready", 32'(S_AXI_AWREADY), 32'd1);
    chk("arb1_arready", 32'(S_AXI_ARREADY), 32'd0);
    if (S_AXI_AWREADY) begin
      tick();
      S_AXI_AWVALID = 1'b0;
      w_phase(12'h100, 0, 32'h5A5A_0001, 4'hF, 0);
      b_phase(0);
    end
    S_AXI_AWADDR  = 12'h104; S_AXI_AWLEN = 8'd0; S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && !S_AXI_ARREADY && n < 200) begin tick(); n++; end
    chk("arb2_arready", 32'(S_AXI_ARREADY), 32'd1);
    chk("arb2_awready", 32'(S_AXI_AWREADY), 32'd0);
    if (S_AXI_ARREADY) begin
      push_read(12'h000, 3);
      tick();
      S_AXI_ARVALID = 1'b0;
      chk("rvalid_lat", 32'(S_AXI_RVALID), 32'd1);
      r_phase(1, -1);
    end
    S_AXI_ARVALID = 1'b0;
    aw_phase(12'h104, 0);
    w_phase(12'h104, 0, 32'h5A5A_0002, 4'hF, 0);
    b_phase(0);
    rd_burst(12'h100, 1, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/rsa_axi_burst_responder.md
RSA_AXI_BURST_RESPONDER -- requirements
Module: rsa_axi_burst_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, byte-address width.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit memory words.
REQ-003 ACLK  in  1  single clock; all logic on its rising edge.
REQ-004 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-005 S_AXI_AWADDR  in  ADDR_WIDTH  write burst start byte address.
REQ-006 S_AXI_AWLEN  in  8  write beats minus one.
REQ-007 S_AXI_AWVALID  in  1  write address valid.
REQ-008 S_AXI_AWREADY  out  1  write address accepted.
REQ-009 S_AXI_WDATA  in  32  write beat data.
REQ-010 S_AXI_WSTRB  in  4  byte enables.
REQ-011 S_AXI_WLAST  in  1  final write beat.
REQ-012 S_AXI_WVALID  in  1  write data valid.
REQ-013 S_AXI_WREADY  out  1  write data accepted.
REQ-014 S_AXI_BRESP  out  2  write response, 00 OKAY, 10 SLVERR.
REQ-015 S_AXI_BVALID  out  1  write response valid.
REQ-016 S_AXI_BREADY  in  1  master accepts response.
REQ-017 S_AXI_ARADDR  in  ADDR_WIDTH  read burst start byte address.
REQ-018 S_AXI_ARLEN  in  8  read beats minus one.
REQ-019 S_AXI_ARVALID  in  1  read address valid.
REQ-020 S_AXI_ARREADY  out  1  read address accepted.
REQ-021 S_AXI_RDATA  out  32  read beat data.
REQ-022 S_AXI_RRESP  out  2  per-beat read response.
REQ-023 S_AXI_RLAST  out  1  final read beat.
REQ-024 S_AXI_RVALID  out  1  read data valid.
REQ-025 S_AXI_RREADY  in  1  master accepts read beat.

Function
REQ-026 SHALL be the responder end of the accelerator M00_AXI burst master: INCR bursts, 32-bit beats, fixed size; one burst in service at a time.
REQ-027 FSM states IDLE, WRITE, WRESP, READ; IDLE is the only state accepting addresses.
REQ-028 IDLE with both AWVALID and ARVALID: grant alternates, write first after reset; AWREADY/ARREADY each a one-cycle pulse only on the granted channel.
REQ-029 AW handshake -> WRITE; WREADY=1 throughout WRITE; each WVALID beat writes enabled bytes of word addr[ADDR_WIDTH-1:2], then word index +1; addr[1:0] ignored.
REQ-030 Beat whose word index >= DEPTH_WORDS: write suppressed, burst marked SLVERR; no wrap-around.
REQ-031 WLAST on beat AWLEN -> WRESP next cycle; WLAST early or missing at beat AWLEN: burst ends at AWLEN+1 beats or at WLAST, whichever first, BRESP=SLVERR.
REQ-032 WRESP: BVALID=1 with BRESP held stable until BREADY; handshake -> IDLE next cycle.
REQ-033 AR handshake in cycle N: RVALID=1 from cycle N+1 with first word; RDATA/RRESP/RLAST stable while RVALID & !RREADY.
REQ-034 Each RVALID&RREADY cycle advances one beat; next beat valid following cycle (1 beat/cycle sustained).
REQ-035 RLAST=1 only on beat ARLEN; its handshake -> IDLE, RVALID=0 next cycle.
REQ-036 Out-of-range read beat: RDATA=0, RRESP=SLVERR, remaining beats still delivered.
REQ-037 AWLEN/ARLEN=0 SHALL be single-beat bursts; 255 SHALL be 256 beats.

Reset
REQ-038 ARESETN low: FSM IDLE, arbiter to write-first, all ready/valid/LAST outputs 0, BRESP/RRESP/RDATA 0, immediately and asynchronously, including mid-burst.
REQ-039 Memory contents SHALL NOT be reset; release SHALL be synchronised so first address accepted no earlier than second rising ACLK after deassertion.

Structure
REQ-040 Package rsa_axi_pkg SHALL hold response codes (OKAY, SLVERR), FSM state enum, data width 32.
REQ-041 Sub-module rsa_word_ram: single-port, byte-enabled, synchronous-read 32-bit RAM of DEPTH_WORDS.

Verification
REQ-042 Write AWADDR 0x000, AWLEN 7, data 1..8, WSTRB F -> BRESP OKAY; read ARADDR 0x000 ARLEN 7 -> 1..8, RLAST beat 8 only.
REQ-043 Write 0xAABBCCDD then single beat 0x11223344 WSTRB 0101 to 0x010 -> read returns 0xAA22CC44.
REQ-044 AWADDR 0xFF8 AWLEN 3, DEPTH 1024 -> words 1022,1023 written, BRESP SLVERR; read same -> beats 3,4 RDATA 0 RRESP SLVERR.
REQ-045 AWVALID and ARVALID together twice -> write granted first, read second; RREADY toggling 1,0,1 -> RDATA held during stall, no beat lost.
REQ-046 ARESETN low at read beat 3 of 8 -> RVALID 0 same cycle; after release, read of 0x000 returns previously written data.
